// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video pixel path.
//   fifo_state_e            : line FIFO serving state (PREFILL, RUN)
//   PIXEL_W                 : pixel width in bits
//   DEFAULT_UNDERFLOW_PIXEL : pixel returned when no real data can be served
// No ports (package).
// ---------------------------------------------------------------------------
package video_pkg;

   localparam int PIXEL_W = 8;

   localparam logic [PIXEL_W-1:0] DEFAULT_UNDERFLOW_PIXEL = 8'h00;

   typedef enum logic {
      PREFILL = 1'b0,
      RUN     = 1'b1
   } fifo_state_e;

endpackage

// File: rtl/pixelstream.sv
// ---------------------------------------------------------------------------
// pixelstream
// Pixel transfer bundle between video blocks.
//   write  : pixel valid, driven by the producer
//   pixel  : pixel data, driven by the producer
//   strobe : driven by the consumer; on a sink it means "space available",
//            on a source it is a one-per-cycle pixel request
// Modports: sink (receives pixels), source (supplies pixels).
// ---------------------------------------------------------------------------
interface pixelstream;

   logic                        write;
   logic [video_pkg::PIXEL_W-1:0] pixel;
   logic                        strobe;

   modport sink   (input  write, input  pixel, output strobe);
   modport source (output write, output pixel, input  strobe);

endinterface

// File: rtl/sync_ram_1r1w.sv
// ---------------------------------------------------------------------------
// sync_ram_1r1w
// Simple dual-port RAM, one write port and one registered read port.
// Provides the one-cycle read latency of the pixel line FIFO.
// Ports:
//   clk        : clock
//   i_wrEn     : write enable
//   i_wrAddr   : write address
//   i_wrData   : write data
//   i_rdEn     : read enable (output register only updates when set)
//   i_rdAddr   : read address
//   o_rdData   : registered read data
// ---------------------------------------------------------------------------
module sync_ram_1r1w #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     i_wrEn,
   input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
   input  logic [WIDTH-1:0]         i_wrData,
   input  logic                     i_rdEn,
   input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
   output logic [WIDTH-1:0]         o_rdData
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdData;

   // Storage array and read register carry no reset so the array can map
   // onto block RAM; the FIFO never consumes stale read data because it
   // tracks which responses came from a real read.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
      if (i_rdEn) begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/pixel_line_fifo.sv
// ---------------------------------------------------------------------------
// pixel_line_fifo
// Elastic pixel buffer between the pixel decoder and the display mixer.
// Pixels are stored in a synchronous RAM; the consumer gets one pixel per
// request, one cycle later. Real pixels are only served once the FIFO has
// been prefilled; a per-line flush empties it and re-enters prefill.
// Ports:
//   clk           : single clock
//   reset         : synchronous, active-high
//   flush         : one-cycle pulse at line start, empties the FIFO
//   in_px         : pixel sink (write/pixel in, strobe = space available)
//   out_px        : pixel source (strobe = request, write/pixel response)
//   level         : current occupancy, 0..DEPTH
//   underflow     : sticky, request in RUN with nothing to serve
//   overflow      : sticky, write dropped because the FIFO was full
//   underflow_cnt : (PIXEL_FIFO_STATS_EN only) saturating underflow count
//   overflow_cnt  : (PIXEL_FIFO_STATS_EN only) saturating dropped-write count
// Build option: define PIXEL_FIFO_STATS_EN to add the two statistics counters.
// ---------------------------------------------------------------------------
module pixel_line_fifo
   import video_pkg::fifo_state_e;
   import video_pkg::PIXEL_W;
#(
   parameter int                 DEPTH           = 1024,
   parameter int                 PREFILL         = 16,
   parameter logic [PIXEL_W-1:0] UNDERFLOW_PIXEL = video_pkg::DEFAULT_UNDERFLOW_PIXEL
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   pixelstream.sink               in_px,
   pixelstream.source             out_px,
   output logic [$clog2(DEPTH):0] level,
   output logic                   underflow,
   output logic                   overflow
`ifdef PIXEL_FIFO_STATS_EN
   ,
   output logic [15:0]            underflow_cnt,
   output logic [15:0]            overflow_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL    = LW'(DEPTH);
   localparam logic [LW-1:0] PREFILL_LEVEL = LW'(PREFILL);

   logic [AW-1:0]      r_wp;
   logic [AW-1:0]      r_rp;
   logic [LW-1:0]      r_level;
   fifo_state_e        r_state;
   logic               r_underflow;
   logic               r_overflow;
   logic               r_outWrite;
   logic               r_servedReal;

   logic               w_notFull;
   logic               w_wrAccept;
   logic               w_wrDrop;
   logic               w_rdReq;
   logic               w_serve;
   logic               w_underReq;
   logic [PIXEL_W-1:0] w_ramData;

   // Traffic qualification. Everything presented during a flush cycle is
   // ignored, so flush gates both the write and the request paths.
   assign w_notFull  = (r_level < FULL_LEVEL);
   assign w_wrAccept = in_px.write && w_notFull && !flush && !reset;
   assign w_wrDrop   = in_px.write && !w_notFull && !flush;
   assign w_rdReq    = out_px.strobe && !flush;
   assign w_serve    = w_rdReq && (r_state == video_pkg::RUN) && (r_level != '0);
   assign w_underReq = w_rdReq && (r_state == video_pkg::RUN) && (r_level == '0);

   sync_ram_1r1w #(
      .DEPTH (DEPTH),
      .WIDTH (PIXEL_W)
   ) u_ram (
      .clk      (clk),
      .i_wrEn   (w_wrAccept),
      .i_wrAddr (r_wp),
      .i_wrData (in_px.pixel),
      .i_rdEn   (w_serve),
      .i_rdAddr (r_rp),
      .o_rdData (w_ramData)
   );

   // Pointer, occupancy, state and sticky-flag control. Reset and flush
   // share one path: both empty the FIFO and return to prefill. The
   // response register is cleared too, since a request in the flush cycle
   // gets no response; a response issued in the previous cycle has already
   // been presented by then. The PREFILL->RUN decision looks at the
   // registered level, so the request in the cycle level first reaches the
   // threshold is still answered as a prefill request.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wp         <= '0;
         r_rp         <= '0;
         r_level      <= '0;
         r_state      <= video_pkg::PREFILL;
         r_underflow  <= 1'b0;
         r_overflow   <= 1'b0;
         r_outWrite   <= 1'b0;
         r_servedReal <= 1'b0;
      end else begin
         if (w_wrAccept) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_serve) begin
            r_rp <= r_rp + 1'b1;
         end
         unique case ({w_wrAccept, w_serve})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if ((r_state == video_pkg::PREFILL) && (r_level >= PREFILL_LEVEL)) begin
            r_state <= video_pkg::RUN;
         end
         if (w_underReq) begin
            r_underflow <= 1'b1;
         end
         if (w_wrDrop) begin
            r_overflow <= 1'b1;
         end
         r_outWrite   <= w_rdReq;
         r_servedReal <= w_serve;
      end
   end

`ifdef PIXEL_FIFO_STATS_EN
   logic [15:0] r_underflowCnt;
   logic [15:0] r_overflowCnt;

   // Saturating event counters; they survive flush so they accumulate
   // across lines and only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_underflowCnt <= '0;
         r_overflowCnt  <= '0;
      end else begin
         if (w_underReq && (r_underflowCnt != 16'hFFFF)) begin
            r_underflowCnt <= r_underflowCnt + 16'd1;
         end
         if (w_wrDrop && (r_overflowCnt != 16'hFFFF)) begin
            r_overflowCnt <= r_overflowCnt + 16'd1;
         end
      end
   end

   assign underflow_cnt = r_underflowCnt;
   assign overflow_cnt  = r_overflowCnt;
`endif

   // The RAM read register only holds meaningful data for responses that
   // came from a real read; every other response shows UNDERFLOW_PIXEL.
   assign out_px.write = r_outWrite;
   assign out_px.pixel = r_servedReal ? w_ramData : UNDERFLOW_PIXEL;
   assign in_px.strobe = w_notFull && !flush;
   assign level        = r_level;
   assign underflow    = r_underflow;
   assign overflow     = r_overflow;

endmodule

// File: doc/pixel_line_fifo.md
# pixel_line_fifo

Elastic pixel buffer between the video pixel decoder and the display mixer. Accepts 8-bit pixels on a `pixelstream.sink` port whenever it has space, holds them in a synchronous RAM, and returns one pixel per consumer request on a `pixelstream.source` port with fixed one-cycle latency. A prefill threshold and a per-line flush keep the mixer from reading half-filled lines. Underflow and overflow are defined, never silent corruption.

## Interface
Parameters:
- `DEPTH`, 1024: entries, power of two, ≥ 4.
- `PREFILL`, 16: occupancy required before serving real pixels, 1 ≤ PREFILL ≤ DEPTH.
- `UNDERFLOW_PIXEL`, 8'h00: pixel returned when no data is available.

Ports (clock and reset first):
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  single-cycle pulse at line start; empties the FIFO and re-enters prefill.
- `in_px`  pixelstream.sink  -  `write`/`pixel` in from the decoder; `strobe` out, meaning "space available".
- `out_px`  pixelstream.source  -  `strobe` in, one consumer request per cycle; `write`/`pixel` out, one-cycle response.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `underflow`  out  1  sticky; set on a request served with UNDERFLOW_PIXEL in RUN; cleared by reset or flush.
- `overflow`  out  1  sticky; set on a write while full; cleared by reset or flush.

## Operation
- Storage: DEPTH×8 RAM, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits and wrapping modulo DEPTH. `level` is a separate counter with range 0..DEPTH.
- `in_px.strobe` = (level < DEPTH) && !flush.
- A write is accepted when `in_px.write` && level < DEPTH. An accepted write stores the pixel at wp, then wp++.
- A write while full is dropped and sets `overflow`.
- States:
  - PREFILL (reset value): a request returns UNDERFLOW_PIXEL and does not advance rp. It is not an underflow. Go to RUN when level ≥ PREFILL, evaluated on the registered level.
  - RUN: a request with level > 0 returns RAM[rp], then rp++. A request with level == 0 returns UNDERFLOW_PIXEL and sets `underflow`. The block stays in RUN.
- Flush, from any state: wp=rp=0, level=0, both stickies cleared, state=PREFILL. A write or read in the flush cycle is ignored. A response already in flight from the previous cycle still completes.
- Simultaneous accepted write and served read: level unchanged. Both pointers advance.
- Read-during-write to the same address cannot occur, because a served read requires level > 0.
- Reset mid-line behaves exactly like flush, and additionally clears `out_px.write`.

## Timing
- Reset values: `out_px.write`=0, `out_px.pixel`=8'h00, `level`=0, `in_px.strobe`=1 (the first cycle after reset), `underflow`=0, `overflow`=0, state PREFILL.
- Request at cycle N gives `out_px.write`=1 with valid `pixel` at N+1, for exactly one cycle. There is no back-pressure on the output.
- A write accepted at N is counted in `level` at N+1. It is readable by a request at N+1, with data at N+2.
- PREFILL→RUN transition happens the cycle after level reaches PREFILL. A request in that same cycle is still a PREFILL request.
- `in_px.strobe` deasserts in the cycle after level reaches DEPTH. A write in that cycle is still accepted only if level < DEPTH; otherwise it is an overflow.
- Sustained throughput is one write and one read per cycle.

## Configuration
- `PIXEL_FIFO_STATS_EN` defined adds two 16-bit saturating output counters:
  - `underflow_cnt`: incremented on every RUN underflow request.
  - `overflow_cnt`: incremented on every dropped write.
  - Both are cleared by reset only, not by flush.
- Undefined: neither the ports nor the logic exist. Sticky flags are unaffected either way.

## Structure
- Shared package `video_pkg` holds:
  - the `fifo_state_e` enum {PREFILL, RUN};
  - `PIXEL_W = 8`;
  - the default `UNDERFLOW_PIXEL`.
- One sub-module, `sync_ram_1r1w` (DEPTH×8, registered read). It supplies the one-cycle read latency. The output `pixel` mux chooses between the RAM output and UNDERFLOW_PIXEL using a registered "served-real" flag.
- Pointers, level, state and stickies live in `pixel_line_fifo`.

## Test plan
- Reset, then write 16 pixels 8'h01..8'h10 with PREFILL=16 → `level`=16. RUN is entered the next cycle. Requests on 16 consecutive cycles return 8'h01..8'h10 in order, each one cycle after its request, and `level` returns to 0.
- DEPTH=8: write 9 pixels back-to-back with no reads → `in_px.strobe` low after the 8th, the 9th is dropped, `overflow`=1, `level`=8.
- In RUN with level=0, issue a request → `out_px.write`=1 with pixel 8'h00 next cycle, `underflow`=1, rp unchanged.
- Simultaneous write and read every cycle for 3·DEPTH cycles across pointer wrap → output sequence equals input sequence delayed, and `level` stays constant.
- Flush with level=5 and a request in the same cycle → request ignored, `level`=0, state PREFILL, stickies cleared. A request before PREFILL is met returns UNDERFLOW_PIXEL without setting `underflow`.
- With `PIXEL_FIFO_STATS_EN`: 3 underflows, then flush, then 2 more → `underflow_cnt`=5. Force 70000 underflows → `underflow_cnt`=16'hFFFF.
